// File: rtl/parity_pkg.sv
// Shared constants, types and helpers for the streaming parity generator/checker.
package parity_pkg;

    localparam int unsigned MODE_GEN   = 0;
    localparam int unsigned MODE_CHECK = 1;

    // Widest beat the helpers accept; narrower beats are zero-extended.
    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    // Zero-extension leaves the XOR reduction unchanged.
    function automatic logic beat_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/parity_stream_if.sv
// Input/output beat streams of the parity block, with DUT-side and source-side views.
interface parity_stream_if #(
    parameter int unsigned DATA_W = 8
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_par;
    logic              s_last;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_par;
    logic              m_last;
    logic              m_frame_par;

    modport slave (
        input  s_valid, s_data, s_par, s_last, m_ready,
        output s_ready, m_valid, m_data, m_par, m_last, m_frame_par
    );

    modport master (
        output s_valid, s_data, s_par, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_par, m_last, m_frame_par
    );

endinterface

// File: rtl/parity_reduce.sv
// Combinational beat parity: XOR of all data bits, inverted for odd parity.
module parity_reduce
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_odd,
    output logic              o_par_c
);

    assign o_par_c = beat_parity(MAX_DATA_W'(i_data), i_odd);

endmodule

// File: rtl/parity_stream.sv
// Streaming per-beat and per-frame parity generator/checker with one output
// register stage and sticky beat-parity / frame-length error flags.
module parity_stream
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CHECK     = 0
) (
    input  logic           clk,
    input  logic           areset_n,
    input  logic           cfg_odd,
    parity_stream_if.slave bus,
    output logic           err_beat,
    output logic           err_len,
    input  logic           err_clr
);

    localparam int unsigned       CNT_W   = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_odd_lat;
    logic               w_odd_nxt;
    logic               r_frame_acc;
    logic               w_acc_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_accept;
    logic               w_odd_eff;
    logic               w_beat_par;
    logic               w_data_xor;
    logic               w_frame_par;
    logic               w_len_set;
    logic               w_beat_set;

    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;
    logic               r_m_par;
    logic               r_m_last;
    logic               r_m_frame_par;
    logic               r_err_beat;
    logic               r_err_len;

    // Ready depends only on the output register, never on s_valid.
    assign bus.s_ready = !r_m_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && bus.s_ready;

    // The first beat of a frame uses the live cfg_odd; later beats use the latched copy.
    assign w_odd_eff   = (r_state == IDLE) ? cfg_odd : r_odd_lat;

    parity_reduce #(
        .DATA_W (DATA_W)
    ) u_reduce (
        .i_data  (bus.s_data),
        .i_odd   (w_odd_eff),
        .o_par_c (w_beat_par)
    );

    assign w_data_xor = w_beat_par ^ w_odd_eff;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_odd_nxt   = r_odd_lat;
        w_acc_nxt   = r_frame_acc;
        w_cnt_nxt   = r_beat_cnt;
        w_len_set   = 1'b0;
        w_beat_set  = 1'b0;
        w_frame_par = 1'b0;

        if (w_accept) begin
            if (CHECK == MODE_CHECK) begin
                w_beat_set = (bus.s_par != w_beat_par);
            end

            case (r_state)
                IDLE: begin
                    w_odd_nxt   = cfg_odd;
                    w_acc_nxt   = w_data_xor;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = bus.s_last ? IDLE : BODY;
                end
                BODY: begin
                    w_acc_nxt = r_frame_acc ^ w_data_xor;
                    // Counter saturates so an over-long frame keeps flagging instead of wrapping.
                    if (r_beat_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_beat_cnt + CNT_ONE;
                    end
                    w_len_set = (r_beat_cnt == CNT_MAX) && !bus.s_last;
                    if (bus.s_last) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (bus.s_last) begin
                w_frame_par = w_acc_nxt ^ w_odd_eff;
                w_cnt_nxt   = '0;
            end
        end
    end

    // Frame context registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_odd_lat   <= 1'b0;
            r_frame_acc <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_odd_lat   <= w_odd_nxt;
            r_frame_acc <= w_acc_nxt;
            r_beat_cnt  <= w_cnt_nxt;
        end
    end

    // Single output stage; holds its contents while stalled.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_par       <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_frame_par <= 1'b0;
        end else if (w_accept) begin
            r_m_valid     <= 1'b1;
            r_m_data      <= bus.s_data;
            r_m_par       <= w_beat_par;
            r_m_last      <= bus.s_last;
            r_m_frame_par <= w_frame_par;
        end else if (bus.m_ready) begin
            r_m_valid     <= 1'b0;
        end
    end

    // Sticky error flags; a new error takes priority over a clear.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_err_beat <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            if (w_beat_set) begin
                r_err_beat <= 1'b1;
            end else if (err_clr) begin
                r_err_beat <= 1'b0;
            end
            if (w_len_set) begin
                r_err_len <= 1'b1;
            end else if (err_clr) begin
                r_err_len <= 1'b0;
            end
        end
    end

    assign bus.m_valid     = r_m_valid;
    assign bus.m_data      = r_m_data;
    assign bus.m_par       = r_m_par;
    assign bus.m_last      = r_m_last;
    assign bus.m_frame_par = r_m_frame_par;
    assign err_beat        = r_err_beat;
    assign err_len         = r_err_len;

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench: a generate-mode instance (MAX_BEATS=4) and a check-mode instance.
module tb_parity_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset_n;
    logic g_cfg_odd, g_err_clr, g_err_beat, g_err_len;
    logic c_cfg_odd, c_err_clr, c_err_beat, c_err_len;

    int total = 0;
    int bad   = 0;

    parity_stream_if #(.DATA_W(8)) g_if ();
    parity_stream_if #(.DATA_W(8)) c_if ();

    parity_stream #(
        .DATA_W    (8),
        .MAX_BEATS (4),
        .CHECK     (0)
    ) u_gen (
        .clk      (clk),
        .areset_n (areset_n),
        .cfg_odd  (g_cfg_odd),
        .bus      (g_if),
        .err_beat (g_err_beat),
        .err_len  (g_err_len),
        .err_clr  (g_err_clr)
    );

    parity_stream #(
        .DATA_W    (8),
        .MAX_BEATS (16),
        .CHECK     (1)
    ) u_chk (
        .clk      (clk),
        .areset_n (areset_n),
        .cfg_odd  (c_cfg_odd),
        .bus      (c_if),
        .err_beat (c_err_beat),
        .err_len  (c_err_len),
        .err_clr  (c_err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired before end of directed sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n  = 1'b0;
        g_cfg_odd = 1'b0;
        c_cfg_odd = 1'b0;
        g_err_clr = 1'b0;
        c_err_clr = 1'b0;
        g_if.s_valid = 1'b0; g_if.s_data = 8'h00; g_if.s_par = 1'b1; g_if.s_last = 1'b0; g_if.m_ready = 1'b1;
        c_if.s_valid = 1'b0; c_if.s_data = 8'h00; c_if.s_par = 1'b0; c_if.s_last = 1'b0; c_if.m_ready = 1'b1;

        // Reset state
        #12;
        chk1("rst_m_valid", g_if.m_valid, 1'b0);
        chk8("rst_m_data", g_if.m_data, 8'h00);
        chk1("rst_m_last", g_if.m_last, 1'b0);
        chk1("rst_m_frame_par", g_if.m_frame_par, 1'b0);
        chk1("rst_err_len", g_err_len, 1'b0);
        chk1("rst_err_beat", c_err_beat, 1'b0);
        areset_n = 1'b1;
        tick();

        // Single-beat frames, even parity
        g_if.s_valid = 1'b1; g_if.s_data = 8'h5A; g_if.s_last = 1'b1;
        tick();
        chk1("5a_valid", g_if.m_valid, 1'b1);
        chk8("5a_data", g_if.m_data, 8'h5A);
        chk1("5a_par", g_if.m_par, 1'b0);
        chk1("5a_last", g_if.m_last, 1'b1);
        chk1("5a_frame_par", g_if.m_frame_par, 1'b0);
        g_if.s_data = 8'h07;
        tick();
        chk8("07_data", g_if.m_data, 8'h07);
        chk1("07_par", g_if.m_par, 1'b1);
        chk1("07_frame_par", g_if.m_frame_par, 1'b1);
        g_if.s_valid = 1'b0;
        tick();
        chk1("idle_valid", g_if.m_valid, 1'b0);

        // Odd-parity 3-beat frame; cfg_odd flips mid-frame and must be ignored
        g_cfg_odd = 1'b1;
        g_if.s_valid = 1'b1; g_if.s_data = 8'h01; g_if.s_last = 1'b0;
        tick();
        chk1("odd_b1_par", g_if.m_par, 1'b0);
        chk1("odd_b1_last", g_if.m_last, 1'b0);
        chk1("odd_b1_frame_par", g_if.m_frame_par, 1'b0);
        g_cfg_odd = 1'b0;
        g_if.s_data = 8'h03;
        tick();
        chk1("odd_b2_par", g_if.m_par, 1'b1);
        g_if.s_data = 8'hFF; g_if.s_last = 1'b1;
        tick();
        chk1("odd_b3_par", g_if.m_par, 1'b1);
        chk1("odd_b3_last", g_if.m_last, 1'b1);
        chk1("odd_b3_frame_par", g_if.m_frame_par, 1'b0);
        g_if.s_valid = 1'b0;
        tick();

        // Backpressure: three stalled cycles, then full throughput
        g_if.s_valid = 1'b1; g_if.s_data = 8'h11; g_if.s_last = 1'b1; g_if.m_ready = 1'b0;
        #1;
        chk1("bp_ready_empty", g_if.s_ready, 1'b1);
        tick();
        g_if.s_data = 8'h22;
        chk1("bp_ready_c1", g_if.s_ready, 1'b0);
        chk8("bp_data_c1", g_if.m_data, 8'h11);
        tick();
        chk1("bp_ready_c2", g_if.s_ready, 1'b0);
        chk8("bp_data_c2", g_if.m_data, 8'h11);
        tick();
        chk1("bp_valid_c3", g_if.m_valid, 1'b1);
        chk8("bp_data_c3", g_if.m_data, 8'h11);
        g_if.m_ready = 1'b1;
        #1;
        chk1("bp_ready_release", g_if.s_ready, 1'b1);
        tick();
        chk8("bp_data_22", g_if.m_data, 8'h22);
        g_if.s_data = 8'h33;
        tick();
        chk8("bp_data_33", g_if.m_data, 8'h33);
        chk1("bp_valid_33", g_if.m_valid, 1'b1);
        g_if.s_valid = 1'b0;
        tick();
        chk1("bp_drained", g_if.m_valid, 1'b0);

        // Over-long frame (6 beats, MAX_BEATS=4); clear on beat 5 loses to the set
        g_if.s_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            g_if.s_data = 8'(i);
            g_if.s_last = (i == 6);
            g_err_clr   = (i == 5);
            tick();
            chk8("len_data", g_if.m_data, 8'(i));
            chk1("len_err", g_err_len, (i >= 5));
        end
        chk1("len_last", g_if.m_last, 1'b1);
        chk1("len_frame_par", g_if.m_frame_par, 1'b1);
        g_if.s_valid = 1'b0;
        g_err_clr = 1'b0;
        chk1("gen_no_err_beat", g_err_beat, 1'b0);
        g_err_clr = 1'b1;
        tick();
        g_err_clr = 1'b0;
        chk1("len_cleared", g_err_len, 1'b0);

        // Check mode: matching then mismatching beat parity
        c_if.s_valid = 1'b1; c_if.s_data = 8'h0F; c_if.s_par = 1'b0; c_if.s_last = 1'b0;
        tick();
        chk1("chk_b1_err", c_err_beat, 1'b0);
        chk1("chk_b1_par", c_if.m_par, 1'b0);
        c_if.s_data = 8'h0E; c_if.s_last = 1'b1;
        tick();
        chk1("chk_b2_err", c_err_beat, 1'b1);
        chk1("chk_b2_par", c_if.m_par, 1'b1);
        chk8("chk_b2_data", c_if.m_data, 8'h0E);
        chk1("chk_b2_frame_par", c_if.m_frame_par, 1'b1);
        c_if.s_valid = 1'b0;
        tick();
        tick();
        chk1("chk_sticky", c_err_beat, 1'b1);
        chk1("chk_no_len_err", c_err_len, 1'b0);
        c_err_clr = 1'b1;
        tick();
        c_err_clr = 1'b0;
        chk1("chk_cleared", c_err_beat, 1'b0);

        // Reset in the middle of an odd-parity frame, then a fresh even frame
        g_cfg_odd = 1'b1;
        g_if.s_valid = 1'b1; g_if.s_data = 8'hA8; g_if.s_last = 1'b0;
        tick();
        g_if.s_data = 8'hBB;
        tick();
        g_if.s_valid = 1'b0;
        areset_n = 1'b0;
        #1;
        chk1("abort_valid", g_if.m_valid, 1'b0);
        chk8("abort_data", g_if.m_data, 8'h00);
        chk1("abort_par", g_if.m_par, 1'b0);
        chk1("abort_last", g_if.m_last, 1'b0);
        chk1("abort_frame_par", g_if.m_frame_par, 1'b0);
        #1;
        areset_n = 1'b1;
        g_cfg_odd = 1'b0;
        g_if.s_valid = 1'b1; g_if.s_data = 8'hFF; g_if.s_last = 1'b1;
        tick();
        chk8("post_data", g_if.m_data, 8'hFF);
        chk1("post_par", g_if.m_par, 1'b0);
        chk1("post_last", g_if.m_last, 1'b1);
        chk1("post_frame_par", g_if.m_frame_par, 1'b0);
        g_if.s_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_stream.md
Name: parity_stream

Overview:
- Streaming parity generator/checker for multi-beat frames of DATA_W-bit words.
- Each beat carries a parity bit, and a frame-level parity is accumulated over all beats and emitted on the last beat.
- In CHECK mode it compares incoming parity against computed parity and raises sticky error flags.
- Sits between a byte/word source and a serial link; supersedes the single-byte combinational even-parity function.

Parameters:
- DATA_W, 8, width of one data beat (1..64).
- MAX_BEATS, 16, maximum beats per frame; longer frames flag a length error (>=2).
- CHECK, 0, 0 = generate mode, 1 = check mode.

Ports:
- clk  in  1  rising-edge clock
- areset_n  in  1  asynchronous active-low reset
- cfg_odd  in  1  0 = even parity, 1 = odd parity; sampled at the first beat of each frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DATA_W  input beat data
- s_par  in  1  received beat parity (CHECK=1 only, ignored otherwise)
- s_last  in  1  last beat of frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  DATA_W  registered copy of s_data
- m_par  out  1  computed beat parity
- m_last  out  1  registered s_last
- m_frame_par  out  1  parity over all frame data bits; meaningful only when m_last=1, otherwise 0
- err_beat  out  1  sticky: beat parity mismatch seen (CHECK=1)
- err_len  out  1  sticky: frame exceeded MAX_BEATS
- err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset (areset_n=0, async): m_valid=0, m_data=0, m_par=0, m_last=0, m_frame_par=0, err_beat=0, err_len=0, beat_cnt=0, frame_acc=0, odd_lat=0, state=IDLE.
- Reset mid-frame aborts the frame; no partial output survives.
- Beat parity = XOR-reduce(s_data) ^ odd_lat.
- Even parity: the beat's data bits plus the parity bit have an even number of ones.
- Single output register stage; latency 1 cycle from accept to m_valid.
- s_ready = !m_valid | m_ready (full throughput, no combinational path from s_valid to s_ready).
- m_* hold stable while m_valid & !m_ready.
- FSM states:
  - IDLE: no frame open. On an accepted beat, latch odd_lat=cfg_odd, set frame_acc = XOR(s_data), beat_cnt=1.
    - If s_last, emit with m_frame_par=frame_acc^cfg_odd and stay in IDLE.
    - Otherwise go to BODY.
  - BODY: on each accepted beat, frame_acc ^= XOR(s_data) and beat_cnt++.
    - On s_last, m_frame_par = final frame_acc ^ odd_lat; return to IDLE.
  - cfg_odd changes while in BODY are ignored until the next frame.
- Length error: if a beat is accepted with beat_cnt==MAX_BEATS and s_last=0, set err_len.
  - The frame continues to pass through.
  - beat_cnt saturates at MAX_BEATS; no wrap.
- Check mode: on each accepted beat, if s_par != computed beat parity, set err_beat (1 cycle after accept).
  - Data still forwarded; m_par = computed value.
- err_clr and a new error in the same cycle: the set wins.
- Single-beat frame (s_last on the first beat): m_frame_par equals m_par.
- Frame width math: frame_acc is 1 bit; parity does not depend on the beat count.

Decomposition:
- parity_pkg holds:
  - mode constants GEN=0, CHECK=1
  - state typedef {IDLE, BODY}
  - function beat_parity(data, odd)
  - width helper for beat_cnt = $clog2(MAX_BEATS+1)
- Sub-module parity_reduce (combinational, parameter DATA_W): in[DATA_W], odd -> par.
  - Instantiated once for s_data.

Test Plan:
- Generate mode, DATA_W=8, cfg_odd=0:
  - single beat 0x5A, s_last=1 -> one cycle later m_par=0, m_frame_par=0, m_last=1.
  - single beat 0x07 -> m_par=1.
- cfg_odd=1, frame 0x01, 0x03, 0xFF (last):
  - m_par = 0, 1, 1 respectively.
  - m_frame_par on the third beat = 1^0^0^1 = 0.
- Backpressure: hold m_ready=0 for 3 cycles with s_valid=1.
  - s_ready=0 from the second cycle; m_data stays fixed.
  - Release -> no beat lost or duplicated; throughput is 1 beat/cycle afterwards.
- Length: MAX_BEATS=4, send 6 beats with s_last on the 6th.
  - err_len rises after the 5th beat accept; all 6 beats are forwarded.
  - err_clr pulse -> err_len=0.
- CHECK=1, even parity, beats 0x0F/s_par=0, then 0x0E/s_par=0:
  - err_beat stays 0 after the first beat.
  - err_beat =1 one cycle after the second beat and stays sticky.
- Assert areset_n=0 mid-frame (after 2 beats) -> all outputs 0 immediately.
  - A new frame 0xFF (last) gives m_frame_par=0, unaffected by the aborted frame.
